// File: rtl/shifter_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational left barrel shifter
// among N_REQ requesters; the result is registered with the winner's ID.
module shifter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int SW    = 3,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*SW-1:0] req_shamt,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       sh_i,
  output logic [SW-1:0]       sh_s,
  input  logic [DW-1:0]       sh_o,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic [IDW-1:0]      rsp_id,
  input  logic                rsp_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, ptr_nxt;
  logic [IDW-1:0] g;
  logic           found;
  logic           can_accept;
  logic [IDW:0]   sum;

  assign rsp_valid  = (state == FULL);
  assign can_accept = !rsp_valid || rsp_ready;

  // Search rr_ptr, rr_ptr+1, ... modulo N_REQ; one extra bit on the index
  // so the wrap also works when N_REQ is not a power of two.
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    if (rst_n && can_accept) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        sum = {1'b0, rr_ptr} + (IDW+1)'(i);
        if (sum >= (IDW+1)'(N_REQ))
          sum = sum - (IDW+1)'(N_REQ);
        if (!found && req_valid[sum[IDW-1:0]]) begin
          found = 1'b1;
          g     = sum[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sh_i      = '0;
    sh_s      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (found && g == IDW'(k)) begin
        req_ready[k] = 1'b1;
        sh_i         = req_data[k*DW +: DW];
        sh_s         = req_shamt[k*SW +: SW];
      end
    end
  end

  always_comb begin
    ptr_nxt = (g == IDW'(N_REQ-1)) ? '0 : g + IDW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (found) state_nxt = FULL;
      FULL: begin
        if (found)          state_nxt = FULL;
        else if (rsp_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (found) begin
        rsp_data <= sh_o;
        rsp_id   <= g;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// Table-driven bench for shifter_rr_arbiter with a response scoreboard;
// the bench supplies the external shifter combinationally.
module tb_shifter_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [11:0] req_shamt;
  logic [3:0]  req_ready;
  logic [7:0]  sh_i;
  logic [2:0]  sh_s;
  logic [7:0]  sh_o;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;

  always #5 clk = ~clk;

  assign sh_o = sh_i << sh_s;

  shifter_rr_arbiter #(.N_REQ(4), .DW(8), .SW(3), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_shamt(req_shamt),
    .req_ready(req_ready),
    .sh_i(sh_i), .sh_s(sh_s), .sh_o(sh_o),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic        do_rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [11:0] shamt;
    logic        rdy;
    logic [3:0]  exp_ready;
  } row_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] id;
  } rsp_t;

  row_t tbl[29];
  rsp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rsp_t e;
    logic post_rst;
    logic [7:0] din;
    logic [2:0] s;
    int k;

    // Reset with every requester valid
    tbl[0]  = '{1, 4'hF, 32'h01010101, 12'h688, 1, 4'h0};
    tbl[1]  = '{1, 4'hF, 32'h01010101, 12'h688, 1, 4'h0};
    // Single request: B2<<5 = 40
    tbl[2]  = '{0, 4'h1, 32'h000000B2, 12'h005, 0, 4'h1};
    tbl[3]  = '{0, 4'h0, 32'h00000000, 12'h000, 0, 4'h0};
    tbl[4]  = '{0, 4'h0, 32'h00000000, 12'h000, 1, 4'h0};
    // Round robin from pointer 0, shamt k per requester
    tbl[5]  = '{1, 4'h0, 32'h00000000, 12'h000, 1, 4'h0};
    tbl[6]  = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h1};
    tbl[7]  = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h2};
    tbl[8]  = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h4};
    tbl[9]  = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h8};
    tbl[10] = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h1};
    tbl[11] = '{0, 4'h0, 32'h00000000, 12'h000, 1, 4'h0};
    // Backpressure: 01<<7 = 80 held for five cycles, then req1 granted on release
    tbl[12] = '{0, 4'h2, 32'h00000100, 12'h038, 1, 4'h2};
    tbl[13] = '{0, 4'h2, 32'h00000300, 12'h008, 0, 4'h0};
    tbl[14] = '{0, 4'h2, 32'h00000300, 12'h008, 0, 4'h0};
    tbl[15] = '{0, 4'h2, 32'h00000300, 12'h008, 0, 4'h0};
    tbl[16] = '{0, 4'h2, 32'h00000300, 12'h008, 0, 4'h0};
    tbl[17] = '{0, 4'h2, 32'h00000300, 12'h008, 0, 4'h0};
    tbl[18] = '{0, 4'h2, 32'h00000300, 12'h008, 1, 4'h2};
    tbl[19] = '{0, 4'h0, 32'h00000000, 12'h000, 1, 4'h0};
    // Pointer wrap/skip: grant 2 (ptr=3), only req1 valid -> 1, then ptr=2
    tbl[20] = '{0, 4'h4, 32'h005A0000, 12'h080, 1, 4'h4};
    tbl[21] = '{0, 4'h2, 32'h0000FF00, 12'h000, 1, 4'h2};
    tbl[22] = '{0, 4'hF, 32'h01010101, 12'h688, 1, 4'h4};
    // Reset while FULL and stalled; pointer must restart at 0
    tbl[23] = '{0, 4'hF, 32'h01010101, 12'h688, 0, 4'h0};
    tbl[24] = '{1, 4'hF, 32'h01010101, 12'h688, 0, 4'h0};
    tbl[25] = '{0, 4'hA, 32'h01010101, 12'h688, 1, 4'h2};
    tbl[26] = '{0, 4'h5, 32'h01010101, 12'h688, 1, 4'h4};
    tbl[27] = '{0, 4'h5, 32'h01010101, 12'h688, 1, 4'h1};
    tbl[28] = '{0, 4'h0, 32'h00000000, 12'h000, 1, 4'h0};

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_shamt = '0; rsp_ready = 1'b0;
    post_rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 29; r++) begin
      rst_n     = !tbl[r].do_rst;
      req_valid = tbl[r].valid;
      req_data  = tbl[r].data;
      req_shamt = tbl[r].shamt;
      rsp_ready = tbl[r].rdy;
      #1;
      chk("req_ready", 32'(req_ready), 32'(tbl[r].exp_ready));
      if (tbl[r].do_rst) begin
        q.delete();
        post_rst = 1'b1;
      end else begin
        if (post_rst) begin
          chk("rst_rsp_data", 32'(rsp_data), 32'h0);
          chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        end
        post_rst = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          if (tbl[r].rdy) void'(q.pop_front());
        end
        k = -1;
        for (int j = 0; j < 4; j++)
          if (tbl[r].exp_ready[j]) k = j;
        if (k >= 0) begin
          din  = tbl[r].data[k*8 +: 8];
          s    = tbl[r].shamt[k*3 +: 3];
          e.d  = din << s;
          e.id = 2'(k);
          chk("sh_i", 32'(sh_i), 32'(din));
          q.push_back(e);
        end else begin
          chk("sh_idle", 32'({sh_i, 5'b0, sh_s}), 32'h0);
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
